// File: rtl/sprite_anim_fetch.sv
// Sprite pixel fetch with per-frame shadow registers, walk-cycle animation and horizontal mirroring.
// Two-stage pipeline: screen hit test / ROM address, then ROM read / color-key transparency.
module sprite_anim_fetch #(
    parameter int SPRITE_W       = 32,
    parameter int SPRITE_H       = 48,
    parameter int FRAMES_PER_DIR = 3,
    parameter int DATA_WIDTH     = 12,
    parameter int ANIM_DIV       = 8,
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 12'hF0F,
    localparam int ADDR_W = $clog2(SPRITE_W*SPRITE_H*FRAMES_PER_DIR*3)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic [9:0]            sprite_x,
    input  logic [9:0]            sprite_y,
    input  logic [1:0]            dir,
    input  logic                  moving,
    input  logic                  pixel_valid,
    input  logic [9:0]            draw_x,
    input  logic [9:0]            draw_y,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] pix_out,
    output logic                  pix_hit,
    output logic                  pix_out_valid
);
    localparam int STEP_W    = (FRAMES_PER_DIR > 1) ? $clog2(FRAMES_PER_DIR) : 1;
    localparam int DIV_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int FRAME_PIX = SPRITE_W * SPRITE_H;

    logic [9:0]            sx_q, sx_d, sy_q, sy_d;
    logic [1:0]            sdir_q, sdir_d;
    logic                  smoving_q, smoving_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic                  hit1_q, hit1_d, v1_q, v1_d;
    logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
    logic [DATA_WIDTH-1:0] pix_out_q, pix_out_d;
    logic                  pix_hit_q, pix_hit_d, pix_out_valid_q, pix_out_valid_d;

    logic [10:0] x_end, y_end;
    logic        in_x, in_y;
    logic [9:0]  lx, ly, lx_m;
    logic [1:0]  row;
    int          frame_idx;

    // Shadow registers and animation counters only move at vblank
    always_comb begin
        sx_d      = sx_q;
        sy_d      = sy_q;
        sdir_d    = sdir_q;
        smoving_d = smoving_q;
        div_cnt_d = div_cnt_q;
        step_d    = step_q;
        if (frame_tick) begin
            sx_d      = sprite_x;
            sy_d      = sprite_y;
            sdir_d    = dir;
            smoving_d = moving;
            if (moving) begin
                if (div_cnt_q == DIV_W'(ANIM_DIV - 1)) begin
                    div_cnt_d = '0;
                    step_d    = (step_q == STEP_W'(FRAMES_PER_DIR - 1)) ? '0 : step_q + STEP_W'(1);
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end else begin
                div_cnt_d = '0;
                step_d    = '0;
            end
        end
    end

    // Stage 1: bounds at 11 bits so a sprite near the right/bottom edge never wraps to column 0
    always_comb begin
        x_end  = {1'b0, sx_q} + 11'(SPRITE_W);
        y_end  = {1'b0, sy_q} + 11'(SPRITE_H);
        in_x   = ({1'b0, draw_x} >= {1'b0, sx_q}) && ({1'b0, draw_x} < x_end);
        in_y   = ({1'b0, draw_y} >= {1'b0, sy_q}) && ({1'b0, draw_y} < y_end);
        lx     = draw_x - sx_q;
        ly     = draw_y - sy_q;
        lx_m   = (sdir_q == 2'd3) ? (10'(SPRITE_W - 1) - lx) : lx;
        case (sdir_q)
            2'd1:    row = 2'd1;
            2'd2:    row = 2'd2;
            default: row = 2'd0;
        endcase
        frame_idx  = int'(row) * FRAMES_PER_DIR + int'(step_q);
        hit1_d     = pixel_valid && in_x && in_y;
        v1_d       = pixel_valid;
        rom_addr_d = hit1_d ? ADDR_W'(frame_idx * FRAME_PIX + int'(ly) * SPRITE_W + int'(lx_m)) : '0;
    end

    // Stage 2: ROM answers combinationally for the registered address
    always_comb begin
        pix_out_valid_d = v1_q;
        pix_hit_d       = hit1_q && (rom_data != TRANSPARENT);
        pix_out_d       = pix_hit_d ? rom_data : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q            <= '0;
            sy_q            <= '0;
            sdir_q          <= '0;
            smoving_q       <= 1'b0;
            div_cnt_q       <= '0;
            step_q          <= '0;
            hit1_q          <= 1'b0;
            v1_q            <= 1'b0;
            rom_addr_q      <= '0;
            pix_out_q       <= '0;
            pix_hit_q       <= 1'b0;
            pix_out_valid_q <= 1'b0;
        end else begin
            sx_q            <= sx_d;
            sy_q            <= sy_d;
            sdir_q          <= sdir_d;
            smoving_q       <= smoving_d;
            div_cnt_q       <= div_cnt_d;
            step_q          <= step_d;
            hit1_q          <= hit1_d;
            v1_q            <= v1_d;
            rom_addr_q      <= rom_addr_d;
            pix_out_q       <= pix_out_d;
            pix_hit_q       <= pix_hit_d;
            pix_out_valid_q <= pix_out_valid_d;
        end
    end

    assign rom_addr      = rom_addr_q;
    assign pix_out       = pix_out_q;
    assign pix_hit       = pix_hit_q;
    assign pix_out_valid = pix_out_valid_q;

endmodule

// File: tb/tb_sprite_anim_fetch.sv
// Bench for sprite_anim_fetch: arithmetic reference model with a two-deep expected pipeline,
// a per-cycle compare process, and literal address/latency expectations for the model itself.
module tb_sprite_anim_fetch;
    localparam int AW = 14;

    typedef struct { logic v; logic hit; logic [AW-1:0] addr; } s1_t;
    typedef struct { logic v; logic hit; logic [11:0] pix; } s2_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_tick = 1'b0;
    logic [9:0]    sprite_x = '0, sprite_y = '0;
    logic [1:0]    dir = '0;
    logic          moving = 1'b0;
    logic          pixel_valid = 1'b0;
    logic [9:0]    draw_x = '0, draw_y = '0;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data, pix_out;
    logic          pix_hit, pix_out_valid;

    logic          force_en = 1'b0;
    logic [11:0]   force_val = '0;

    int  checks = 0, failures = 0;
    bit  chk_on = 1'b0;
    int  m_sx = 0, m_sy = 0, m_dir = 0, m_cnt = 0;
    s1_t e1 = '{1'b0, 1'b0, '0};
    s2_t e2 = '{1'b0, 1'b0, '0};

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(input logic [AW-1:0] a);
        if (a[2:0] == 3'd5) return 12'hF0F;
        return a[11:0] ^ 12'hA5C;
    endfunction

    assign rom_data = force_en ? force_val : rom_f(rom_addr);

    sprite_anim_fetch dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .dir(dir), .moving(moving),
        .pixel_valid(pixel_valid), .draw_x(draw_x), .draw_y(draw_y),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_out(pix_out), .pix_hit(pix_hit), .pix_out_valid(pix_out_valid)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, req, $time);
        end
    endtask

    // Walk step is the number of consecutive moving ticks divided by 8, modulo 3
    function automatic s1_t model_s1(input logic pv, input int dx, input int dy);
        s1_t r;
        int lx, ly, row, step;
        r.v    = pv;
        r.hit  = pv && dx >= m_sx && dx < m_sx + 32 && dy >= m_sy && dy < m_sy + 48;
        lx     = dx - m_sx;
        ly     = dy - m_sy;
        if (m_dir == 3) lx = 31 - lx;
        row    = (m_dir == 1) ? 1 : (m_dir == 2) ? 2 : 0;
        step   = (m_cnt / 8) % 3;
        r.addr = r.hit ? AW'((row * 3 + step) * 1536 + ly * 32 + lx) : '0;
        return r;
    endfunction

    task automatic cycle();
        s1_t c;
        s2_t n;
        logic [11:0] rv;
        if (rst) begin
            c = '{1'b0, 1'b0, '0};
            n = '{1'b0, 1'b0, '0};
        end else begin
            c     = model_s1(pixel_valid, int'(draw_x), int'(draw_y));
            rv    = force_en ? force_val : rom_f(e1.addr);
            n.v   = e1.v;
            n.hit = e1.hit && (rv != 12'hF0F);
            n.pix = n.hit ? rv : 12'h000;
        end
        @(posedge clk);
        e2 = n;
        e1 = c;
        if (rst) begin
            m_sx = 0; m_sy = 0; m_dir = 0; m_cnt = 0;
        end else if (frame_tick) begin
            m_sx  = int'(sprite_x);
            m_sy  = int'(sprite_y);
            m_dir = int'(dir);
            m_cnt = moving ? m_cnt + 1 : 0;
        end
        #1;
    endtask

    task automatic tick(input int x, input int y, input int d, input bit mv);
        sprite_x = 10'(x); sprite_y = 10'(y); dir = 2'(d); moving = mv;
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        draw_x = 10'(x); draw_y = 10'(y); pixel_valid = 1'b1;
        cycle();
        pixel_valid = 1'b0;
    endtask

    task automatic pix_lit(input string n, input int x, input int y, input int lit);
        pix(x, y);
        chk(n, 32'(rom_addr), 32'(lit));
        chk({n, "_model"}, 32'(e1.addr), 32'(lit));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rom_addr", 32'(rom_addr), 32'(e1.addr));
            chk("pix_out_valid", 32'(pix_out_valid), 32'(e2.v));
            chk("pix_hit", 32'(pix_hit), 32'(e2.hit));
            chk("pix_out", 32'(pix_out), 32'(e2.pix));
            chk("rom_addr_in_depth", 32'(rom_addr < AW'(13824)), 32'd1);
        end
    end

    initial begin
        cycle();
        cycle();
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_pix_out", 32'(pix_out), 0);
        chk("rst_pix_hit", 32'(pix_hit), 0);
        chk("rst_valid", 32'(pix_out_valid), 0);
        chk_on = 1'b1;
        rst = 1'b0;
        cycle();

        // Basic hit / address
        tick(100, 50, 0, 1'b0);
        pix_lit("addr_origin", 100, 50, 0);
        pix_lit("addr_corner", 131, 97, 1535);
        pix_lit("addr_right_out", 132, 50, 0);
        pix_lit("addr_left_out", 99, 50, 0);
        pix_lit("addr_below_out", 100, 98, 0);
        cycle();
        chk("miss_hit", 32'(pix_hit), 0);

        // Mirror and direction rows
        tick(100, 50, 3, 1'b0);
        pix_lit("mirror_origin", 100, 50, 31);
        pix_lit("mirror_right", 131, 51, 32);
        tick(100, 50, 2, 1'b0);
        pix_lit("down_base", 100, 50, 9216);
        tick(100, 50, 1, 1'b0);
        pix_lit("up_base", 100, 50, 4608);

        // Transparency and exact two-cycle latency
        tick(100, 50, 0, 1'b0);
        cycle();
        force_en = 1'b1; force_val = 12'hF0F;
        pix(110, 60);
        cycle();
        chk("transp_valid", 32'(pix_out_valid), 1);
        chk("transp_hit", 32'(pix_hit), 0);
        chk("transp_out", 32'(pix_out), 0);
        force_val = 12'h123;
        pix(110, 60);
        chk("lat1_valid", 32'(pix_out_valid), 0);
        cycle();
        chk("lat2_valid", 32'(pix_out_valid), 1);
        chk("opaque_hit", 32'(pix_hit), 1);
        chk("opaque_out", 32'(pix_out), 32'h123);
        force_en = 1'b0;

        // Tearing: position change without frame_tick is ignored
        sprite_x = 10'd200;
        pix_lit("tear_old_hit", 101, 50, 1);
        pix_lit("tear_new_miss", 201, 50, 0);
        tick(200, 50, 0, 1'b0);
        pix_lit("tear_after_tick", 201, 50, 1);

        // frame_tick coincident with a pixel uses the old shadows
        sprite_x = 10'd300; frame_tick = 1'b1;
        pix_lit("coincident_old", 201, 50, 1);
        frame_tick = 1'b0;
        pix_lit("coincident_new", 301, 50, 1);

        // Animation
        for (int i = 0; i < 7; i++) tick(100, 50, 0, 1'b1);
        pix_lit("anim_7", 100, 50, 0);
        tick(100, 50, 0, 1'b1);
        pix_lit("anim_8", 100, 50, 1536);
        tick(100, 50, 1, 1'b1);
        pix_lit("anim_dirchg", 100, 50, 6144);
        for (int i = 0; i < 7; i++) tick(100, 50, 0, 1'b1);
        pix_lit("anim_16", 100, 50, 3072);
        for (int i = 0; i < 8; i++) tick(100, 50, 0, 1'b1);
        pix_lit("anim_24_wrap", 100, 50, 0);
        for (int i = 0; i < 8; i++) tick(100, 50, 0, 1'b1);
        pix_lit("anim_32", 100, 50, 1536);
        tick(100, 50, 0, 1'b0);
        pix_lit("anim_stand", 100, 50, 0);
        tick(100, 50, 0, 1'b1);
        pix_lit("anim_restart", 100, 50, 0);

        // Sprite hanging off the bottom-right corner
        tick(1000, 1000, 0, 1'b0);
        pix_lit("edge_in", 1023, 1023, 759);
        pix_lit("edge_nowrap", 0, 0, 0);
        pix_lit("edge_nowrap_y", 1010, 5, 0);

        // Scattered pixels around a mirrored sprite
        tick(400, 200, 3, 1'b0);
        for (int i = 0; i < 60; i++) begin
            draw_x = 10'(397 + $urandom_range(0, 38));
            draw_y = 10'(197 + $urandom_range(0, 54));
            pixel_valid = ($urandom_range(0, 3) != 0);
            cycle();
        end
        pixel_valid = 1'b0;

        // Asynchronous reset mid-scan with a non-zero step
        for (int i = 0; i < 8; i++) tick(100, 50, 0, 1'b1);
        pix_lit("pre_rst_step1", 100, 50, 1536);
        draw_x = 10'd101; draw_y = 10'd50; pixel_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("arst_rom_addr", 32'(rom_addr), 0);
        chk("arst_pix_out", 32'(pix_out), 0);
        chk("arst_pix_hit", 32'(pix_hit), 0);
        chk("arst_valid", 32'(pix_out_valid), 0);
        e1 = '{1'b0, 1'b0, '0};
        e2 = '{1'b0, 1'b0, '0};
        m_sx = 0; m_sy = 0; m_dir = 0; m_cnt = 0;
        cycle();
        pixel_valid = 1'b0;
        rst = 1'b0;
        cycle();
        pix_lit("post_rst_step0", 5, 0, 5);
        chk("post_rst_lat1", 32'(pix_out_valid), 0);
        cycle();
        chk("post_rst_lat2", 32'(pix_out_valid), 1);
        cycle();
        cycle();

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
